// File: rtl/spi_arbitro_transacciones_if.sv
// Signal bundle between the bus-side requesters, the SPI transaction arbiter
// and the SPI register ports. Per-requester fields are packed, requester k at slice k.
interface spi_arbitro_transacciones_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      start_i;
    logic [NREQ*9-1:0]    n_tx_i;
    logic [NREQ-1:0]      all0_i;
    logic [NREQ-1:0]      all1_i;
    logic [NREQ-1:0]      keep_cs_i;
    logic [NREQ-1:0]      dat_we_i;
    logic [NREQ*10-1:0]   dat_addr_i;
    logic [NREQ*32-1:0]   dat_wdata_i;
    logic [31:0]          dat_rdata_o;
    logic [NREQ-1:0]      done_o;
    logic [NREQ-1:0]      err_o;
    logic [9:0]           rx_count_o;
    logic [31:0]          spi_ctrl_i;
    logic [31:0]          spi_data_i;
    logic                 spi_we_ctrl_o;
    logic [31:0]          spi_ctrl_o;
    logic                 spi_we_data_o;
    logic [9:0]           spi_addr_o;
    logic [31:0]          spi_data_o;

    modport master (
        output req_i, start_i, n_tx_i, all0_i, all1_i, keep_cs_i,
               dat_we_i, dat_addr_i, dat_wdata_i, spi_ctrl_i, spi_data_i,
        input  gnt_o, dat_rdata_o, done_o, err_o, rx_count_o,
               spi_we_ctrl_o, spi_ctrl_o, spi_we_data_o, spi_addr_o, spi_data_o
    );

    modport slave (
        input  req_i, start_i, n_tx_i, all0_i, all1_i, keep_cs_i,
               dat_we_i, dat_addr_i, dat_wdata_i, spi_ctrl_i, spi_data_i,
        output gnt_o, dat_rdata_o, done_o, err_o, rx_count_o,
               spi_we_ctrl_o, spi_ctrl_o, spi_we_data_o, spi_addr_o, spi_data_o
    );
endinterface

// File: rtl/spi_arbitro_transacciones.sv
// Round-robin arbiter sharing one SPI peripheral between NREQ requesters: the
// granted requester owns the data buffer, launches transfers and gets done/err.
module spi_arbitro_transacciones #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 500000,
    parameter int SETTLE_CYC  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    spi_arbitro_transacciones_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_BUSY    = 3'd3,
        ST_FIN     = 3'd4,
        ST_ABORT   = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [NREQ-1:0] gnt_r;
    logic [IW-1:0]   gidx_r;
    logic [IW-1:0]   rr_r;
    logic            cs_held_r;
    logic [TW-1:0]   timer_r;
    logic [9:0]      rx_count_r;

    logic [IW-1:0]   pick_idx_s;
    logic            pick_found_s;
    logic [IW-1:0]   rr_next_s;
    logic            gnt_any_s;
    logic            req_g_s;
    logic            start_g_s;
    logic            keep_cs_g_s;
    logic            all0_g_s;
    logic            all1_g_s;
    logic            dat_we_g_s;
    logic [8:0]      n_tx_g_s;
    logic            poll_s;
    logic            timeout_s;
    logic            spi_we_ctrl_s;
    logic [31:0]     spi_ctrl_s;
    logic            unused_ctrl_bits_s;

    assign req_g_s     = bus.req_i[gidx_r];
    assign start_g_s   = bus.start_i[gidx_r];
    assign keep_cs_g_s = bus.keep_cs_i[gidx_r];
    assign all0_g_s    = bus.all0_i[gidx_r];
    assign all1_g_s    = bus.all1_i[gidx_r];
    assign dat_we_g_s  = bus.dat_we_i[gidx_r];
    assign n_tx_g_s    = bus.n_tx_i[int'(gidx_r)*9 +: 9];
    assign gnt_any_s   = |gnt_r;

    // The send bit is only trusted once the launch write has had time to land.
    assign poll_s    = (timer_r >= TW'(SETTLE_CYC));
    assign timeout_s = (timer_r == TW'(TIMEOUT_CYC - 1));
    assign rr_next_s = (gidx_r == IW'(NREQ - 1)) ? {IW{1'b0}} : gidx_r + IW'(1'b1);

    assign unused_ctrl_bits_s = ^{bus.spi_ctrl_i[31:26], bus.spi_ctrl_i[15:1]};

    // Round-robin pick: first requesting index at or after the rr pointer.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = rr_r;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found_s && bus.req_i[(int'(rr_r) + k) % NREQ]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IW'((int'(rr_r) + k) % NREQ);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Session FSM: next state and SPI control-register write strobe/value.
    always_comb begin
        state_s       = state_r;
        spi_we_ctrl_s = 1'b0;
        spi_ctrl_s    = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // A dropped request beats a simultaneous start pulse.
                if (!req_g_s) begin
                    if (cs_held_r) begin
                        state_s = ST_RELEASE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (start_g_s) begin
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_LAUNCH: begin
                state_s       = ST_BUSY;
                spi_we_ctrl_s = 1'b1;
                spi_ctrl_s    = {19'h0_0000, n_tx_g_s, all0_g_s, all1_g_s, 1'b1, 1'b1};
            end
            ST_BUSY: begin
                if (poll_s && !bus.spi_ctrl_i[0]) begin
                    state_s = ST_FIN;
                end else if (timeout_s) begin
                    state_s = ST_ABORT;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_FIN: begin
                state_s       = ST_LOAD;
                spi_we_ctrl_s = !keep_cs_g_s;
            end
            ST_ABORT: begin
                state_s       = ST_LOAD;
                spi_we_ctrl_s = 1'b1;
            end
            ST_RELEASE: begin
                state_s       = ST_IDLE;
                spi_we_ctrl_s = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, grant/rr bookkeeping, CS tracking, BUSY timer and rx count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {NREQ{1'b0}};
            gidx_r     <= {IW{1'b0}};
            rr_r       <= {IW{1'b0}};
            cs_held_r  <= 1'b0;
            timer_r    <= {TW{1'b0}};
            rx_count_r <= 10'd0;
        end else begin
            state_r <= state_s;
            timer_r <= (state_r == ST_BUSY) ? timer_r + TW'(1'b1) : {TW{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        gidx_r <= pick_idx_s;
                        gnt_r  <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    end
                end
                ST_LOAD: begin
                    if (!req_g_s) begin
                        gnt_r <= {NREQ{1'b0}};
                        rr_r  <= rr_next_s;
                    end
                end
                ST_LAUNCH: begin
                    cs_held_r <= 1'b1;
                end
                ST_FIN: begin
                    rx_count_r <= bus.spi_ctrl_i[25:16];
                    if (!keep_cs_g_s) begin
                        cs_held_r <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    cs_held_r <= 1'b0;
                end
                ST_RELEASE: begin
                    cs_held_r <= 1'b0;
                end
                default: begin
                    cs_held_r <= cs_held_r;
                end
            endcase
        end
    end

    assign bus.gnt_o         = gnt_r;
    assign bus.done_o        = (state_r == ST_FIN)   ? gnt_r : {NREQ{1'b0}};
    assign bus.err_o         = (state_r == ST_ABORT) ? gnt_r : {NREQ{1'b0}};
    assign bus.rx_count_o    = rx_count_r;
    assign bus.spi_we_ctrl_o = spi_we_ctrl_s;
    assign bus.spi_ctrl_o    = spi_ctrl_s;
    // Only the owner's buffer port reaches the SPI, and writes only while loading.
    assign bus.spi_we_data_o = (state_r == ST_LOAD) && dat_we_g_s;
    assign bus.spi_addr_o    = gnt_any_s ? bus.dat_addr_i[int'(gidx_r)*10 +: 10]  : 10'd0;
    assign bus.spi_data_o    = gnt_any_s ? bus.dat_wdata_i[int'(gidx_r)*32 +: 32] : 32'h0000_0000;
    assign bus.dat_rdata_o   = gnt_any_s ? bus.spi_data_i : 32'h0000_0000;

endmodule

// File: tb/tb_spi_arbitro_transacciones.sv
// Directed bench for spi_arbitro_transacciones with a small SPI control-register
// model that clears the send bit a fixed number of cycles after each launch.
module tb_spi_arbitro_transacciones;
    localparam int NREQ    = 2;
    localparam int CLR_CYC = 40;

    logic        clk_i = 1'b0;
    logic        rst_i;
    int          checks = 0;
    int          errors = 0;
    int          n;
    logic        auto_clr;
    logic [9:0]  rx_val;
    logic [31:0] ctrl_m = 32'h0000_0000;
    int          clr_cnt = 0;

    spi_arbitro_transacciones_if #(.NREQ(NREQ)) ifc ();

    spi_arbitro_transacciones #(
        .NREQ(NREQ),
        .TIMEOUT_CYC(100),
        .SETTLE_CYC(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(ifc)
    );

    always #5 clk_i = ~clk_i;

    // SPI control register: captures writes, clears send CLR_CYC cycles after a launch.
    always @(posedge clk_i) begin
        if (ifc.spi_we_ctrl_o) begin
            ctrl_m  <= ifc.spi_ctrl_o;
            clr_cnt <= 0;
        end else if (ctrl_m[0] && auto_clr && clr_cnt == CLR_CYC - 1) begin
            ctrl_m[0]     <= 1'b0;
            ctrl_m[25:16] <= rx_val;
        end else if (ctrl_m[0]) begin
            clr_cnt <= clr_cnt + 1;
        end
    end
    assign ifc.spi_ctrl_i = ctrl_m;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_event(input int bound);
        n = 0;
        while (ifc.done_o == 2'b00 && ifc.err_o == 2'b00 && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_i           = 1'b0;
        auto_clr        = 1'b1;
        rx_val          = 10'd3;
        ifc.req_i       = 2'b00;
        ifc.start_i     = 2'b00;
        ifc.n_tx_i      = 18'd0;
        ifc.all0_i      = 2'b00;
        ifc.all1_i      = 2'b00;
        ifc.keep_cs_i   = 2'b00;
        ifc.dat_we_i    = 2'b00;
        ifc.dat_addr_i  = 20'd0;
        ifc.dat_wdata_i = 64'd0;
        ifc.spi_data_i  = 32'hDEAD_BEEF;
        #12;
        check("rst_gnt", 32'(ifc.gnt_o), 32'h0);
        check("rst_we_ctrl", 32'(ifc.spi_we_ctrl_o), 32'h0);
        check("rst_ctrl", ifc.spi_ctrl_o, 32'h0);
        check("rst_we_data", 32'(ifc.spi_we_data_o), 32'h0);
        check("rst_done_err", 32'({ifc.done_o, ifc.err_o}), 32'h0);
        check("rst_rx", 32'(ifc.rx_count_o), 32'h0);
        check("rst_rdata", ifc.dat_rdata_o, 32'h0);
        rst_i = 1'b1;

        // Round robin
        ifc.req_i = 2'b11;
        tick();
        check("rr_first", 32'(ifc.gnt_o), 32'h1);
        ifc.req_i = 2'b10;
        tick();
        check("rr_gap", 32'(ifc.gnt_o), 32'h0);
        tick();
        check("rr_second", 32'(ifc.gnt_o), 32'h2);
        ifc.req_i = 2'b01;
        tick();
        check("rr_gap2", 32'(ifc.gnt_o), 32'h0);
        ifc.req_i = 2'b11;
        tick();
        check("rr_third", 32'(ifc.gnt_o), 32'h1);

        // Normal transfer, n_tx=3
        ifc.n_tx_i[8:0] = 9'd3;
        ifc.start_i     = 2'b01;
        tick();
        ifc.start_i = 2'b00;
        check("launch_we", 32'(ifc.spi_we_ctrl_o), 32'h1);
        check("launch_ctrl", ifc.spi_ctrl_o, 32'h0000_0033);
        tick();
        ifc.dat_we_i = 2'b01;
        #1;
        check("busy_we_data", 32'(ifc.spi_we_data_o), 32'h0);
        check("busy_we_ctrl", 32'(ifc.spi_we_ctrl_o), 32'h0);
        ifc.dat_we_i = 2'b00;
        wait_event(200);
        check("done_latency", n, 32'd41);
        check("fin_done", 32'(ifc.done_o), 32'h1);
        check("fin_err", 32'(ifc.err_o), 32'h0);
        check("fin_we_ctrl", 32'(ifc.spi_we_ctrl_o), 32'h1);
        check("fin_ctrl", ifc.spi_ctrl_o, 32'h0);
        tick();
        check("done_pulse", 32'(ifc.done_o), 32'h0);
        check("rx_count", 32'(ifc.rx_count_o), 32'd3);
        check("gnt_kept", 32'(ifc.gnt_o), 32'h1);

        // Data-buffer routing while loading
        ifc.dat_addr_i[19:10]  = 10'd5;
        ifc.dat_wdata_i[63:32] = 32'h0000_00AB;
        ifc.dat_we_i           = 2'b10;
        #1;
        check("route_other", 32'(ifc.spi_we_data_o), 32'h0);
        ifc.dat_addr_i[9:0]   = 10'd5;
        ifc.dat_wdata_i[31:0] = 32'h0000_00AB;
        ifc.dat_we_i          = 2'b01;
        #1;
        check("route_we", 32'(ifc.spi_we_data_o), 32'h1);
        check("route_addr", 32'(ifc.spi_addr_o), 32'd5);
        check("route_data", ifc.spi_data_o, 32'h0000_00AB);
        check("rdata_pass", ifc.dat_rdata_o, 32'hDEAD_BEEF);
        ifc.dat_we_i = 2'b00;

        // Multi-part transfer with CS held; n_tx=0, all0 and all1 both set
        ifc.keep_cs_i   = 2'b01;
        ifc.n_tx_i[8:0] = 9'd0;
        ifc.all0_i      = 2'b01;
        ifc.all1_i      = 2'b01;
        rx_val          = 10'd7;
        for (int part = 0; part < 2; part++) begin
            ifc.start_i = 2'b01;
            tick();
            ifc.start_i = 2'b00;
            check("keep_launch_ctrl", ifc.spi_ctrl_o, 32'h0000_000F);
            tick();
            wait_event(200);
            check("keep_latency", n, 32'd41);
            check("keep_fin_no_write", 32'(ifc.spi_we_ctrl_o), 32'h0);
            tick();
            check("keep_rx", 32'(ifc.rx_count_o), 32'd7);
        end
        ifc.req_i = 2'b00;
        tick();
        check("release_we", 32'(ifc.spi_we_ctrl_o), 32'h1);
        check("release_ctrl", ifc.spi_ctrl_o, 32'h0);
        check("release_gnt", 32'(ifc.gnt_o), 32'h0);
        tick();
        check("idle_we", 32'(ifc.spi_we_ctrl_o), 32'h0);
        ifc.keep_cs_i = 2'b00;
        ifc.all0_i    = 2'b00;
        ifc.all1_i    = 2'b00;

        // Timeout: send never clears
        auto_clr        = 1'b0;
        ifc.n_tx_i[8:0] = 9'd3;
        ifc.req_i       = 2'b01;
        tick();
        check("to_gnt", 32'(ifc.gnt_o), 32'h1);
        ifc.start_i = 2'b01;
        tick();
        ifc.start_i = 2'b00;
        tick();
        wait_event(300);
        check("to_latency", n, 32'd100);
        check("to_err", 32'(ifc.err_o), 32'h1);
        check("to_done", 32'(ifc.done_o), 32'h0);
        check("to_we_ctrl", 32'(ifc.spi_we_ctrl_o), 32'h1);
        check("to_ctrl", ifc.spi_ctrl_o, 32'h0);
        check("to_rx_kept", 32'(ifc.rx_count_o), 32'd7);
        tick();
        check("to_err_pulse", 32'(ifc.err_o), 32'h0);

        // Reset in the middle of BUSY
        ifc.start_i = 2'b01;
        tick();
        ifc.start_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        ifc.dat_we_i = 2'b01;
        rst_i        = 1'b0;
        #1;
        check("arst_gnt", 32'(ifc.gnt_o), 32'h0);
        check("arst_we_ctrl", 32'(ifc.spi_we_ctrl_o), 32'h0);
        check("arst_we_data", 32'(ifc.spi_we_data_o), 32'h0);
        rst_i        = 1'b1;
        ifc.dat_we_i = 2'b00;
        tick();
        check("regrant", 32'(ifc.gnt_o), 32'h1);

        // Request drop and start in the same cycle: drop wins
        ifc.req_i   = 2'b00;
        ifc.start_i = 2'b01;
        tick();
        ifc.start_i = 2'b00;
        check("drop_gnt", 32'(ifc.gnt_o), 32'h0);
        check("drop_no_launch", 32'(ifc.spi_we_ctrl_o), 32'h0);
        tick();
        check("drop_no_launch2", 32'(ifc.spi_we_ctrl_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
